// File: rtl/mpt_pkg.sv
// Shared types for the PLB tag store: tag entry layout and invalidate FSM states.
`default_nettype none

package mpt_pkg;

  // Entries carry a tag at the widest supported size; narrower tags are zero-extended.
  localparam int MPT_TAG_MAX_W = 64;

  typedef enum logic [1:0] {
    PLB_IDLE  = 2'd0,
    PLB_FLUSH = 2'd1,
    PLB_DONE  = 2'd2
  } plb_inval_state_e;

  typedef struct packed {
    logic                     valid;
    logic [MPT_TAG_MAX_W-1:0] tag;
  } plb_entry_t;

endpackage

`default_nettype wire

// File: rtl/plb_tag_store.sv
// plb_tag_store: flop-based page-tag lookup/insert/remove store on a PLB MEM slave
// port, with a sequential invalidate-all FSM. Rev 1.0
`default_nettype none

module plb_tag_store
  import mpt_pkg::*;
#(
  parameter int NUM_ENTRIES      = 8,
  parameter int PLB_ADDR_WIDTH   = 64,
  parameter int PLB_DATA_WIDTH   = 64,
  parameter int PAGE_OFFSET_BITS = 12
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        plb_slave_mem_req,
  output logic                        plb_slave_mem_gnt,
  output logic                        plb_slave_mem_valid,
  input  logic [PLB_ADDR_WIDTH-1:0]   plb_slave_mem_addr,
  output logic [PLB_DATA_WIDTH-1:0]   plb_slave_mem_rdata,
  input  logic [PLB_DATA_WIDTH-1:0]   plb_slave_mem_wdata,
  input  logic                        plb_slave_mem_we,
  input  logic [PLB_DATA_WIDTH/8-1:0] plb_slave_mem_be,
  output logic                        plb_slave_mem_error,
  input  logic                        inval_req_i,
  output logic                        inval_done_o
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);

  plb_inval_state_e state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  plb_entry_t       entry_q [NUM_ENTRIES];
  plb_entry_t       entry_d [NUM_ENTRIES];
  logic             valid_q, valid_d;
  logic             hit_q, hit_d;
  logic             error_q, error_d;

  logic [MPT_TAG_MAX_W-1:0] req_tag;
  logic                     hit;
  logic [IDX_W-1:0]         match_idx;
  logic                     free_found;
  logic [IDX_W-1:0]         free_idx;

  logic unused_bits;
  assign unused_bits = ^{plb_slave_mem_addr[PAGE_OFFSET_BITS-1:0],
                         plb_slave_mem_wdata[PLB_DATA_WIDTH-1:1]};

  assign req_tag =
    MPT_TAG_MAX_W'(plb_slave_mem_addr[PLB_ADDR_WIDTH-1:PAGE_OFFSET_BITS]);

  // Tag match and lowest-index free slot; the descending loop leaves the lowest free index.
  always_comb begin
    hit        = 1'b0;
    match_idx  = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (entry_q[i].valid && (entry_q[i].tag == req_tag)) begin
        hit       = 1'b1;
        match_idx = IDX_W'(i);
      end
    end
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!entry_q[i].valid) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= PLB_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      PLB_IDLE:  if (inval_req_i) state_d = PLB_FLUSH;
      PLB_FLUSH: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(NUM_ENTRIES - 1)) state_d = PLB_DONE;
      end
      PLB_DONE:  state_d = PLB_IDLE;
      default:   state_d = PLB_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    plb_slave_mem_gnt = plb_slave_mem_req && (state_q == PLB_IDLE);
    inval_done_o      = (state_q == PLB_DONE);
  end

  // Requests are only granted in IDLE, so they never collide with flush updates.
  always_comb begin
    entry_d = entry_q;
    rr_d    = rr_q;
    valid_d = plb_slave_mem_gnt;
    hit_d   = 1'b0;
    error_d = 1'b0;
    if (plb_slave_mem_gnt) begin
      if (!plb_slave_mem_we) begin
        hit_d = hit;
      end else if (plb_slave_mem_be != '1) begin
        error_d = 1'b1;
      end else if (plb_slave_mem_wdata[0]) begin
        if (!hit) begin
          if (free_found) begin
            entry_d[free_idx] = '{valid: 1'b1, tag: req_tag};
          end else begin
            entry_d[rr_q] = '{valid: 1'b1, tag: req_tag};
            rr_d          = rr_q + 1'b1;
          end
        end
      end else if (hit) begin
        entry_d[match_idx].valid = 1'b0;
      end
    end
    if (state_q == PLB_FLUSH) entry_d[cnt_q].valid = 1'b0;
    if (state_q == PLB_DONE)  rr_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_ENTRIES; i++) entry_q[i] <= '0;
      rr_q    <= '0;
      valid_q <= 1'b0;
      hit_q   <= 1'b0;
      error_q <= 1'b0;
    end else begin
      entry_q <= entry_d;
      rr_q    <= rr_d;
      valid_q <= valid_d;
      hit_q   <= hit_d;
      error_q <= error_d;
    end
  end

  assign plb_slave_mem_valid = valid_q;
  assign plb_slave_mem_rdata = {{(PLB_DATA_WIDTH-1){1'b0}}, hit_q};
  assign plb_slave_mem_error = error_q;

endmodule

`default_nettype wire
